// File: rtl/voice_pkg.sv
// Shared definitions for the polyphonic voice allocator: defaults, FSM states
// and the per-voice table entry.
package voice_pkg;

    localparam int unsigned NUM_VOICES_DEF  = 8;
    localparam logic [31:0] FULL_VOLUME_DEF = 32'd1 << 20;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_COMMIT = 2'd2
    } alloc_state_t;

    typedef struct packed {
        logic [7:0]  key;
        logic [15:0] freq;
        logic        active;
    } voice_entry_t;

endpackage

// File: rtl/voice_lru.sv
// Least-recently-used rank table: rank 0 is the most recent voice,
// rank NUM_VOICES-1 the oldest. Ranks always form a permutation.
module voice_lru
    import voice_pkg::*;
#(
    parameter int unsigned NUM_VOICES = NUM_VOICES_DEF,
    localparam int unsigned IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          touch,
    input  logic [IW-1:0] touch_idx,
    output logic [IW-1:0] oldest_idx
);

    logic [IW-1:0] rank [NUM_VOICES];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_VOICES; i++) begin
                rank[i] <= IW'(i);
            end
        end else if (touch) begin
            // Voices more recent than the touched one age by one step.
            for (int unsigned i = 0; i < NUM_VOICES; i++) begin
                if (rank[i] < rank[touch_idx]) begin
                    rank[i] <= rank[i] + 1'b1;
                end
            end
            rank[touch_idx] <= '0;
        end
    end

    always_comb begin
        oldest_idx = '0;
        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            if (rank[i] == IW'(NUM_VOICES - 1)) begin
                oldest_idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: sequentially scans the voice table for each key
// event, then retriggers, assigns, steals or releases a voice on COMMIT.
module voice_allocator
    import voice_pkg::*;
#(
    parameter int unsigned NUM_VOICES  = NUM_VOICES_DEF,
    parameter logic [31:0] FULL_VOLUME = FULL_VOLUME_DEF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ev_valid,
    output logic                         ev_ready,
    input  logic                         ev_note_on,
    input  logic [7:0]                   ev_key,
    input  logic [15:0]                  ev_freq,
    output logic [NUM_VOICES-1:0][15:0]  frequencies,
    output logic [NUM_VOICES-1:0][31:0]  voice_volumes,
    output logic [NUM_VOICES-1:0]        active_mask,
    output logic                         steal_pulse
);

    localparam int unsigned IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int unsigned CW = $clog2(NUM_VOICES + 1);

    alloc_state_t  state;
    logic [CW-1:0] idx;
    logic [IW-1:0] cur_idx;
    voice_entry_t  voices [NUM_VOICES];
    voice_entry_t  cur;

    logic          lat_on;
    logic [7:0]    lat_key;
    logic [15:0]   lat_freq;
    logic          match_found;
    logic [IW-1:0] match_idx;
    logic          free_found;
    logic [IW-1:0] free_idx;

    logic          touch;
    logic [IW-1:0] touch_idx;
    logic [IW-1:0] oldest_idx;

    assign ev_ready = (state == ST_IDLE);
    assign cur_idx  = idx[IW-1:0];
    assign cur      = voices[cur_idx];

    always_comb begin
        touch     = (state == ST_COMMIT) && lat_on;
        touch_idx = oldest_idx;
        if (match_found) begin
            touch_idx = match_idx;
        end else if (free_found) begin
            touch_idx = free_idx;
        end
    end

    voice_lru #(
        .NUM_VOICES (NUM_VOICES)
    ) u_lru (
        .clk        (clk),
        .reset      (reset),
        .touch      (touch),
        .touch_idx  (touch_idx),
        .oldest_idx (oldest_idx)
    );

    // SCAN spends one extra terminal cycle at idx == NUM_VOICES, giving the
    // NUM_VOICES+2 accept-to-output latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            idx         <= '0;
            lat_on      <= 1'b0;
            lat_key     <= '0;
            lat_freq    <= '0;
            match_found <= 1'b0;
            match_idx   <= '0;
            free_found  <= 1'b0;
            free_idx    <= '0;
            steal_pulse <= 1'b0;
            for (int unsigned i = 0; i < NUM_VOICES; i++) begin
                voices[i] <= '0;
            end
        end else begin
            steal_pulse <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (ev_valid) begin
                        lat_on      <= ev_note_on;
                        lat_key     <= ev_key;
                        lat_freq    <= ev_freq;
                        idx         <= '0;
                        match_found <= 1'b0;
                        free_found  <= 1'b0;
                        state       <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (idx == CW'(NUM_VOICES)) begin
                        state <= ST_COMMIT;
                    end else begin
                        if (cur.active && cur.key == lat_key && !match_found) begin
                            match_found <= 1'b1;
                            match_idx   <= cur_idx;
                        end
                        if (!cur.active && !free_found) begin
                            free_found <= 1'b1;
                            free_idx   <= cur_idx;
                        end
                        idx <= idx + 1'b1;
                    end
                end
                ST_COMMIT: begin
                    state <= ST_IDLE;
                    if (lat_on) begin
                        if (match_found) begin
                            voices[match_idx].freq <= lat_freq;
                        end else if (free_found) begin
                            voices[free_idx].key    <= lat_key;
                            voices[free_idx].freq   <= lat_freq;
                            voices[free_idx].active <= 1'b1;
                        end else begin
                            voices[oldest_idx].key  <= lat_key;
                            voices[oldest_idx].freq <= lat_freq;
                            steal_pulse             <= 1'b1;
                        end
                    end else if (match_found) begin
                        voices[match_idx].active <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            frequencies[i]   = voices[i].freq;
            active_mask[i]   = voices[i].active;
            voice_volumes[i] = voices[i].active ? FULL_VOLUME : '0;
        end
    end

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator: allocation, retrigger, release,
// stealing, latency and reset abort against hand-computed values.
module tb_voice_allocator;

    localparam int unsigned NV   = 8;
    localparam logic [31:0] FULL = 32'd1 << 20;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  ev_valid = 1'b0;
    logic                  ev_ready;
    logic                  ev_note_on = 1'b0;
    logic [7:0]            ev_key = '0;
    logic [15:0]           ev_freq = '0;
    logic [NV-1:0][15:0]   frequencies;
    logic [NV-1:0][31:0]   voice_volumes;
    logic [NV-1:0]         active_mask;
    logic                  steal_pulse;

    int errors = 0;
    int checks = 0;
    int low_cnt;
    int out_changed;

    always #5 clk = ~clk;

    voice_allocator #(
        .NUM_VOICES  (NV),
        .FULL_VOLUME (FULL)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .ev_valid      (ev_valid),
        .ev_ready      (ev_ready),
        .ev_note_on    (ev_note_on),
        .ev_key        (ev_key),
        .ev_freq       (ev_freq),
        .frequencies   (frequencies),
        .voice_volumes (voice_volumes),
        .active_mask   (active_mask),
        .steal_pulse   (steal_pulse)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Presents one event, scrambles the inputs while the allocator is busy,
    // and returns at the negedge following the commit edge.
    task automatic send(input logic on, input logic [7:0] key, input logic [15:0] freq);
        logic [NV-1:0][15:0] snap_f;
        logic [NV-1:0]       snap_m;
        int waited;
        waited = 0;
        while (!ev_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!ev_ready) begin
            check("ready_timeout", 256'(ev_ready), 256'(1));
            return;
        end
        snap_f     = frequencies;
        snap_m     = active_mask;
        ev_valid   = 1'b1;
        ev_note_on = on;
        ev_key     = key;
        ev_freq    = freq;
        @(posedge clk);
        @(negedge clk);
        ev_valid   = 1'b0;
        ev_note_on = ~on;
        ev_key     = 8'hFF;
        ev_freq    = 16'hFFFF;
        low_cnt     = 0;
        out_changed = 0;
        for (int k = 0; k < int'(NV) + 2; k++) begin
            if (k > 0) @(negedge clk);
            if (!ev_ready) low_cnt++;
            if (frequencies !== snap_f || active_mask !== snap_m) out_changed++;
        end
        @(negedge clk);
    endtask

    initial begin
        logic [NV-1:0][15:0] exp_f;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        check("rst_freqs", 256'(frequencies), 256'(0));
        check("rst_vols", 256'(voice_volumes), 256'(0));
        check("rst_mask", 256'(active_mask), 256'(0));
        check("rst_ready", 256'(ev_ready), 256'(1));
        check("rst_steal", 256'(steal_pulse), 256'(0));

        send(1'b1, 8'h15, 16'd3520);
        check("lat_ready_low", 256'(low_cnt), 256'(10));
        check("lat_no_early", 256'(out_changed), 256'(0));
        check("p1_ready", 256'(ev_ready), 256'(1));
        check("p1_freq0", 256'(frequencies[0]), 256'(3520));
        check("p1_vol0", 256'(voice_volumes[0]), 256'(FULL));
        check("p1_mask", 256'(active_mask), 256'(8'h01));

        send(1'b1, 8'h4A, 16'd4400);
        check("p2_freq1", 256'(frequencies[1]), 256'(4400));
        check("p2_vol1", 256'(voice_volumes[1]), 256'(FULL));
        check("p2_mask", 256'(active_mask), 256'(8'h03));

        send(1'b0, 8'h15, 16'd0);
        check("rel_vol0", 256'(voice_volumes[0]), 256'(0));
        check("rel_freq0", 256'(frequencies[0]), 256'(3520));
        check("rel_freq1", 256'(frequencies[1]), 256'(4400));
        check("rel_vol1", 256'(voice_volumes[1]), 256'(FULL));
        check("rel_mask", 256'(active_mask), 256'(8'h02));

        // Freed voice 0 is the lowest free slot again.
        send(1'b1, 8'h33, 16'd1234);
        check("reuse_freq0", 256'(frequencies[0]), 256'(1234));
        check("reuse_mask", 256'(active_mask), 256'(8'h03));

        do_reset();
        exp_f = '0;
        for (int i = 0; i < int'(NV); i++) begin
            send(1'b1, 8'(8'h20 + i), 16'(100 * i + 100));
            exp_f[i] = 16'(100 * i + 100);
        end
        check("fill_mask", 256'(active_mask), 256'(8'hFF));
        check("fill_freqs", 256'(frequencies), 256'(exp_f));
        check("fill_nosteal", 256'(steal_pulse), 256'(0));
        send(1'b1, 8'h30, 16'd28160);
        exp_f[0] = 16'd28160;
        check("steal_pulse", 256'(steal_pulse), 256'(1));
        check("steal_freqs", 256'(frequencies), 256'(exp_f));
        check("steal_mask", 256'(active_mask), 256'(8'hFF));
        @(negedge clk);
        check("steal_once", 256'(steal_pulse), 256'(0));
        // Voice 1 is now the oldest.
        send(1'b1, 8'h31, 16'd500);
        exp_f[1] = 16'd500;
        check("steal2_freqs", 256'(frequencies), 256'(exp_f));
        check("steal2_pulse", 256'(steal_pulse), 256'(1));

        do_reset();
        send(1'b1, 8'h15, 16'd3520);
        send(1'b1, 8'h15, 16'd7040);
        check("retrig_mask", 256'(active_mask), 256'(8'h01));
        check("retrig_freq0", 256'(frequencies[0]), 256'(7040));
        check("retrig_freq1", 256'(frequencies[1]), 256'(0));
        check("retrig_nosteal", 256'(steal_pulse), 256'(0));
        send(1'b0, 8'h1C, 16'd0);
        check("relunk_mask", 256'(active_mask), 256'(8'h01));
        check("relunk_freq0", 256'(frequencies[0]), 256'(7040));
        check("relunk_vol0", 256'(voice_volumes[0]), 256'(FULL));

        do_reset();
        ev_valid   = 1'b1;
        ev_note_on = 1'b1;
        ev_key     = 8'h40;
        ev_freq    = 16'd999;
        @(posedge clk);
        @(negedge clk);
        ev_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("abort_ready", 256'(ev_ready), 256'(1));
        repeat (12) @(negedge clk);
        check("abort_mask", 256'(active_mask), 256'(0));
        check("abort_freqs", 256'(frequencies), 256'(0));
        check("abort_vols", 256'(voice_volumes), 256'(0));
        send(1'b1, 8'h41, 16'd2000);
        check("post_abort_freq0", 256'(frequencies[0]), 256'(2000));
        check("post_abort_mask", 256'(active_mask), 256'(8'h01));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
